// File: rtl/mem_dump_tx_pkg.sv
// Shared types and constants for the data-memory UART dump block.
package mem_dump_tx_pkg;

    localparam int unsigned FRAME_BITS     = 10;
    localparam int unsigned BYTES_PER_WORD = 3;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StSend,
        StWait,
        StFin
    } state_e;

    // Byte 0 is the most significant byte of the 24-bit word.
    function automatic logic [7:0] word_byte(input logic [23:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    return word[23:16];
            2'd1:    return word[15:8];
            default: return word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/mem_dump_tx_uart_tx.sv
// 8N1 UART serializer: one start bit, eight data bits LSB first, one stop bit.
module uart_tx
    import mem_dump_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       tx,
    output logic       tx_done
);

    localparam int unsigned     CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      BitLast  = 4'(FRAME_BITS - 1);

    logic            active_q;
    logic [CntW-1:0] baud_q;
    logic [3:0]      bit_q;
    logic [8:0]      shift_q;
    logic            tx_q;
    logic            bit_end;

    assign bit_end = active_q && (baud_q == BaudLast);
    // Combinational so the caller can launch the next frame one cycle after the stop bit.
    assign tx_done = bit_end && (bit_q == BitLast);
    assign tx      = tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else if (!active_q) begin
            if (tx_start) begin
                active_q <= 1'b1;
                baud_q   <= '0;
                bit_q    <= '0;
                shift_q  <= {1'b1, tx_byte};
                tx_q     <= 1'b0;
            end
        end else if (bit_end) begin
            baud_q <= '0;
            if (tx_done) begin
                active_q <= 1'b0;
                tx_q     <= 1'b1;
            end else begin
                bit_q   <= bit_q + 4'd1;
                tx_q    <= shift_q[0];
                shift_q <= {1'b1, shift_q[8:1]};
            end
        end else begin
            baud_q <= baud_q + CntW'(1);
        end
    end

endmodule

// File: rtl/mem_dump_tx.sv
// Walks data memory words 0..NUM_WORDS-1 and sends each as three UART bytes, MSB first.
module mem_dump_tx
    import mem_dump_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned NUM_WORDS    = 19
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  rd_addr,
    input  logic [23:0] rd_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] AddrLast = 5'(NUM_WORDS - 1);
    localparam logic [1:0] IdxLast  = 2'(BYTES_PER_WORD - 1);

    state_e      state_q, state_d;
    logic [23:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic [4:0]  addr_q, addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        tx_start;
    logic        tx_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            word_q  <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tx_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A start coinciding with the done pulse belongs to the dump just finished.
                if (start && !done_q) begin
                    busy_d  = 1'b1;
                    addr_d  = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                word_d  = rd_data;
                idx_d   = '0;
                state_d = StSend;
            end
            StSend: begin
                tx_start = 1'b1;
                state_d  = StWait;
            end
            StWait: begin
                if (tx_done) begin
                    if (idx_q < IdxLast) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = StSend;
                    end else if (addr_q < AddrLast) begin
                        addr_d  = addr_q + 5'd1;
                        state_d = StFetch;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StFin: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                addr_d  = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_start(tx_start),
        .tx_byte (word_byte(word_q, idx_q)),
        .tx      (tx),
        .tx_done (tx_done)
    );

    assign rd_addr = addr_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Randomized bench for mem_dump_tx: a sampling UART receiver and a byte-queue model.
module tb_mem_dump_tx;

    localparam int unsigned CPB       = 4;
    localparam int unsigned NW        = 2;
    localparam int          FRAME_CYC = 10 * CPB;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  rd_addr;
    logic [23:0] rd_data;
    logic        tx;
    logic        busy;
    logic        done;

    logic [23:0] mem [32];
    logic [23:0] noise     = '0;
    bit          scramble  = 1'b0;
    bit          fetch_win = 1'b0;

    int          vectors   = 0;
    int          errors    = 0;
    int unsigned cyc       = 0;
    byte unsigned exp_q[$];
    int          frame_idx    = 0;
    int          exp_busy_len = 0;
    int          done_seen    = 0;

    // Outside the fetch window the memory port returns garbage every cycle.
    assign rd_data = (scramble && !fetch_win) ? noise : mem[rd_addr];

    always #5 clk = ~clk;

    mem_dump_tx #(
        .CLKS_PER_BIT(CPB),
        .NUM_WORDS   (NW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin : cyc_count
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin : noise_gen
        forever begin
            @(negedge clk);
            noise = 24'($urandom);
        end
    end

    initial begin : rx_mon
        bit         active;
        int         cnt;
        int         idle;
        logic       samp [FRAME_CYC];
        logic [7:0] byte_v;
        bit         ok;
        active = 1'b0;
        cnt    = 0;
        idle   = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active    = 1'b0;
                idle      = 0;
                fetch_win = 1'b0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    if (frame_idx > 0) check_eq("gap", idle, (frame_idx % 3 == 0) ? 2 : 1);
                    active    = 1'b1;
                    samp[0]   = 1'b0;
                    cnt       = 1;
                    fetch_win = 1'b0;
                end else begin
                    idle++;
                end
            end else begin
                samp[cnt] = tx;
                cnt++;
                if (cnt == FRAME_CYC) begin
                    ok = 1'b1;
                    for (int k = 0; k < FRAME_CYC; k++)
                        if (samp[k] !== samp[(k / CPB) * CPB]) ok = 1'b0;
                    if (samp[0] !== 1'b0 || samp[FRAME_CYC-1] !== 1'b1) ok = 1'b0;
                    for (int j = 0; j < 8; j++) byte_v[j] = samp[(j + 1) * CPB];
                    check_eq("framing", 32'(ok), 1);
                    check_eq("frame_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) check_eq("byte", byte_v, exp_q.pop_front());
                    if (frame_idx % 3 == 2) fetch_win = 1'b1;
                    frame_idx++;
                    active = 1'b0;
                    idle   = 0;
                end
            end
        end
    end

    initial begin : busy_mon
        int   len;
        logic prev;
        len  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                len  = 0;
                prev = 1'b0;
            end else begin
                if (done === 1'b1) done_seen++;
                if (busy === 1'b1) begin
                    len++;
                end else if (prev === 1'b1) begin
                    check_eq("busy_len", len, exp_busy_len);
                    check_eq("done_at_busy_fall", done, 1);
                    len = 0;
                end
                prev = busy;
            end
        end
    end

    task automatic run_dump(input bit scr, input bit poke, input bit do_rst);
        int unsigned e0;
        int unsigned len;
        int unsigned r;
        int          base;
        // Accept-to-first-start-bit, all frames, intra-word gaps, inter-word gaps, FIN edge.
        len = 2 + 3 * NW * FRAME_CYC + (3 * NW - NW) * 1 + (NW - 1) * 2 + 1;
        exp_q.delete();
        for (int w = 0; w < NW; w++)
            for (int b = 0; b < 3; b++) exp_q.push_back(8'(mem[w] >> (16 - 8 * b)));
        exp_busy_len = len;
        frame_idx    = 0;
        scramble     = scr;
        fetch_win    = 1'b1;
        base         = done_seen;

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        e0 = cyc;
        @(negedge clk);
        check_eq("busy_after_accept", busy, 1);
        check_eq("tx_idle_fetch", tx, 1);
        @(negedge clk);
        check_eq("tx_idle_send", tx, 1);
        @(negedge clk);
        check_eq("tx_fall", tx, 0);

        if (do_rst) begin
            // One edge into the start bit of the third frame.
            while (cyc < e0 + 2 + 2 * (FRAME_CYC + 1) + 1) begin
                @(posedge clk);
                #1;
            end
            rst_n = 1'b0;
            #1;
            check_eq("rst_tx", tx, 1);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_done", done, 0);
            check_eq("rst_addr", rd_addr, 0);
            scramble = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            exp_q.delete();
            repeat (5) @(negedge clk);
            check_eq("post_rst_tx", tx, 1);
            check_eq("post_rst_busy", busy, 0);
            return;
        end

        if (poke) begin
            r = $urandom_range(10, len - 20);
            while (cyc < e0 + r) begin
                @(posedge clk);
                #1;
            end
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        while (cyc < e0 + len - 2) begin
            @(posedge clk);
            #1;
        end
        if (poke) begin
            // Held across the last WAIT edge, the FIN edge and the done cycle.
            start = 1'b1;
            while (cyc < e0 + len + 1) begin
                @(posedge clk);
                #1;
            end
            start = 1'b0;
        end
        while (cyc < e0 + len + 20) begin
            @(posedge clk);
            #1;
        end
        check_eq("done_pulses", done_seen - base, 1);
        check_eq("bytes_left", exp_q.size(), 0);
        check_eq("busy_end", busy, 0);
        check_eq("addr_end", rd_addr, 0);
        scramble = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : main
        for (int i = 0; i < 32; i++) mem[i] = 24'($urandom);
        #2 rst_n = 1'b0;
        #2;
        check_eq("reset_tx", tx, 1);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_addr", rd_addr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        mem[0] = 24'hA53C0F;
        run_dump(1'b0, 1'b0, 1'b0);
        mem[0] = 24'h000001;
        mem[1] = 24'hFFFFFF;
        run_dump(1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) begin
            mem[0] = 24'($urandom);
            mem[1] = 24'($urandom);
            run_dump(1'b1, 1'b0, 1'b0);
        end
        mem[0] = 24'($urandom);
        run_dump(1'b1, 1'b1, 1'b0);
        run_dump(1'b0, 1'b0, 1'b1);
        mem[0] = 24'($urandom);
        mem[1] = 24'($urandom);
        run_dump(1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
